adder_result_buffer: RTL and testbench

ADDER_RESULT_BUFFER -- requirements
Module: adder_result_buffer

---
 rtl/adder_pkg.sv | 27 ++
 rtl/adder_result_fifo_mem.sv | 47 ++++
 rtl/adder_result_buffer.sv | 114 +++++++++++
 tb/tb_adder_result_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and widths for the 4-bit adder result path.
// Holds the buffered entry layout and the saturation helper.
package adder_pkg;

  localparam int WIDTH   = 4;
  localparam int COUNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
  } result_t;

  localparam int ENTRY_W = $bits(result_t);

  // Clamp a signed overflow to the representable extreme on the side the
  // true result lies: a negative-looking wrapped sum means a positive overflow.
  function automatic result_t saturate(input result_t r);
    result_t s;
    s = r;
    if (r.overflow) begin
      s.sum = r.sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
    return s;
  endfunction

endpackage

// File: rtl/adder_result_fifo_mem.sv
// Circular storage array with wrapping read/write pointers.
// Push/pop qualification (full/empty) is the caller's responsibility.
module adder_result_fifo_mem #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the array is deliberately not reset; stale words are unreachable
  // once the pointers clear, and the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/adder_result_buffer.sv
// First-word-fall-through buffer for adder results with overflow statistics.
// Optional: define ADDER_RESULT_SATURATE_EN to store saturated sums on overflow.
module adder_result_buffer
  import adder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_sum,
  input  logic                   in_carryout,
  input  logic                   in_overflow,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_sum,
  output logic                   out_carryout,
  output logic                   out_overflow,
  input  logic                   clear,
  output logic                   ovf_sticky,
  output logic [COUNT_W-1:0]     ovf_count,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [LVL_W-1:0]   level_q, level_d;
  logic [COUNT_W-1:0] ovf_count_q, ovf_count_d;
  logic               ovf_sticky_q, ovf_sticky_d;
  logic               rdy_en_q;
  logic               push, pop;
  result_t            wr_entry, head;

  // Holds in_ready low while reset is asserted and releases it on the
  // first edge afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  assign in_ready  = rdy_en_q && (level_q != LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef ADDER_RESULT_SATURATE_EN
  assign wr_entry = saturate('{sum: in_sum, carryout: in_carryout, overflow: in_overflow});
`else
  assign wr_entry = '{sum: in_sum, carryout: in_carryout, overflow: in_overflow};
`endif

  adder_result_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head)
  );

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    level_d      = level_q;
    ovf_count_d  = ovf_count_q;
    ovf_sticky_d = ovf_sticky_q;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Clear takes priority, so a coincident overflow push is not counted.
    if (clear) begin
      ovf_count_d  = '0;
      ovf_sticky_d = 1'b0;
    end else if (push && in_overflow) begin
      ovf_sticky_d = 1'b1;
      if (ovf_count_q != '1) begin
        ovf_count_d = ovf_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q      <= '0;
      ovf_count_q  <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      level_q      <= level_d;
      ovf_count_q  <= ovf_count_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign level      = level_q;
  assign ovf_count  = ovf_count_q;
  assign ovf_sticky = ovf_sticky_q;

  // Masking with out_valid keeps unwritten storage off the outputs.
  assign out_sum      = out_valid ? head.sum      : '0;
  assign out_carryout = out_valid ? head.carryout : 1'b0;
  assign out_overflow = out_valid ? head.overflow : 1'b0;

endmodule

// File: tb/tb_adder_result_buffer.sv
// Scoreboard bench for adder_result_buffer: accepted pushes queue expected
// entries, a negedge monitor pops and compares each retired head.
module tb_adder_result_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] sum;
    logic       c;
    logic       o;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [3:0] in_sum;
  logic       in_carryout, in_overflow;
  logic       out_valid, out_ready;
  logic [3:0] out_sum;
  logic       out_carryout, out_overflow;
  logic       clear;
  logic       ovf_sticky;
  logic [7:0] ovf_count;
  logic [2:0] level;

  ent_t q[$];
  ent_t sb_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  adder_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_carryout  (in_carryout),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carryout (out_carryout),
    .out_overflow (out_overflow),
    .clear        (clear),
    .ovf_sticky   (ovf_sticky),
    .ovf_count    (ovf_count),
    .level        (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic ent_t expect_entry(input logic [3:0] s, input logic c, input logic o);
    ent_t e;
    e.sum = s;
`ifdef ADDER_RESULT_SATURATE_EN
    if (o) e.sum = s[3] ? 4'b0111 : 4'b1000;
`endif
    e.c = c;
    e.o = o;
    return e;
  endfunction

  // Scoreboard: single owner of the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          sb_e = q.pop_front();
          check("out_entry", {26'd0, out_sum, out_carryout, out_overflow}, {26'd0, sb_e});
        end
      end
      if (in_valid && in_ready) q.push_back(expect_entry(in_sum, in_carryout, in_overflow));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] s, input logic c, input logic o);
    in_valid    = 1'b1;
    in_sum      = s;
    in_carryout = c;
    in_overflow = o;
  endtask

  task automatic push1(input logic [3:0] s, input logic c, input logic o);
    set_in(s, c, o);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (level != 3'd0 && n < 50) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("drain_level", 32'(level), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] a, s;
    logic [4:0] r;
    logic [3:0] exp_sum_a, exp_sum_b;

`ifdef ADDER_RESULT_SATURATE_EN
    exp_sum_a = 4'b0111;
    exp_sum_b = 4'b1000;
`else
    exp_sum_a = 4'b1010;
    exp_sum_b = 4'b0101;
`endif

    reset = 1'b1; in_valid = 1'b0; in_sum = '0; in_carryout = 1'b0;
    in_overflow = 1'b0; out_ready = 1'b0; clear = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ovf_count", 32'(ovf_count), 32'd0);
    check("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    reset = 1'b0;
    tick();
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // 7+3 overflows to 1010; no combinational bypass before the edge.
    set_in(4'b1010, 1'b0, 1'b1);
    #1;
    check("no_bypass", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("a_out_valid", 32'(out_valid), 32'd1);
    check("a_out_sum", 32'(out_sum), 32'(exp_sum_a));
    check("a_out_overflow", 32'(out_overflow), 32'd1);
    check("a_level", 32'(level), 32'd1);
    check("a_ovf_count", 32'(ovf_count), 32'd1);
    check("a_ovf_sticky", 32'(ovf_sticky), 32'd1);
    tick();
    check("a_hold_sum", 32'(out_sum), 32'(exp_sum_a));
    drain();

    // -5 + -6 overflows to 0101 with carryout.
    push1(4'b0101, 1'b1, 1'b1);
    check("b_out_sum", 32'(out_sum), 32'(exp_sum_b));
    check("b_out_carry", 32'(out_carryout), 32'd1);
    check("b_out_overflow", 32'(out_overflow), 32'd1);
    check("b_ovf_count", 32'(ovf_count), 32'd2);
    drain();

    // Fill to DEPTH, then pop with in_valid held: full blocks the push.
    for (int i = 0; i < DEPTH; i++) push1(4'(i), 1'b0, 1'b0);
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("sticky_held", 32'(ovf_sticky), 32'd1);
    set_in(4'hF, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("full_pop_level", 32'(level), 32'(DEPTH - 1));
    check("full_pop_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Streaming a + 1 for a = -8..7 across several pointer wraps.
    for (int i = 0; i < 16; i++) begin
      a = 4'(i + 8);
      r = {1'b0, a} + 5'd1;
      s = r[3:0];
      set_in(s, r[4], !a[3] && s[3]);
      out_ready = (i != 0);
      tick();
      if (i != 0) check("stream_level", 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("stream_end_level", 32'(level), 32'd0);
    check("stream_ovf_count", 32'(ovf_count), 32'd3);

    // 300 overflow pushes saturate the counter.
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      set_in(4'b1010, 1'b0, 1'b1);
      tick();
      if (k == 250) check("ovf_count_254", 32'(ovf_count), 32'd254);
    end
    in_valid = 1'b0;
    check("ovf_count_sat", 32'(ovf_count), 32'd255);
    drain();

    set_in(4'b1010, 1'b0, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_ovf_count", 32'(ovf_count), 32'd0);
    check("clear_ovf_sticky", 32'(ovf_sticky), 32'd0);
    check("clear_keeps_fifo", 32'(level), 32'd1);
    drain();

    // Reset mid-burst with three stored entries.
    for (int i = 0; i < 3; i++) push1(4'(i + 2), 1'b0, 1'b1);
    check("pre_rst_level", 32'(level), 32'd3);
    check("pre_rst_ovf_count", 32'(ovf_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ovf_count", 32'(ovf_count), 32'd0);
    check("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
    check("mid_rst_out_sum", 32'(out_sum), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_level", 32'(level), 32'd0);
    push1(4'b0011, 1'b0, 1'b0);
    check("post_rst_push_level", 32'(level), 32'd1);
    drain();

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
